sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 43 ++++
 rtl/sdram_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the two request ports, the arbiter and the SDRAM controller.
// The master modport is the environment side; the slave modport is the arbiter side.
interface sdram_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [24:0] a_addr;
  logic [15:0] a_din;
  logic [1:0]  a_wtbt;
  logic [15:0] a_dout;
  logic        a_ack;
  logic        a_busy;
  logic        b_req;
  logic        b_we;
  logic [24:0] b_addr;
  logic [15:0] b_din;
  logic [1:0]  b_wtbt;
  logic [15:0] b_dout;
  logic        b_ack;
  logic        b_busy;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wtbt;
  logic        mem_we;
  logic        mem_rd;
  logic [15:0] mem_dout;
  logic        mem_ready;

  modport master (
    output a_req, a_we, a_addr, a_din, a_wtbt,
    output b_req, b_we, b_addr, b_din, b_wtbt,
    input  a_dout, a_ack, a_busy, b_dout, b_ack, b_busy,
    input  mem_addr, mem_din, mem_wtbt, mem_we, mem_rd,
    output mem_dout, mem_ready
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din, a_wtbt,
    input  b_req, b_we, b_addr, b_din, b_wtbt,
    output a_dout, a_ack, a_busy, b_dout, b_ack, b_busy,
    output mem_addr, mem_din, mem_wtbt, mem_we, mem_rd,
    input  mem_dout, mem_ready
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter (A = CPU, B = DMA/video) feeding a level-strobed controller.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; default is fixed A priority.
module sdram_arbiter (
  input  logic            clk,
  input  logic            reset,
  sdram_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic        a_we_q, a_we_d, b_we_q, b_we_d;
  logic [24:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [15:0] a_din_q, a_din_d, b_din_q, b_din_d;
  logic [1:0]  a_wtbt_q, a_wtbt_d, b_wtbt_q, b_wtbt_d;
  logic        gnt_b_q, gnt_b_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic [1:0]  mem_wtbt_q, mem_wtbt_d;
  logic        mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
  logic [15:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic        pick_b_s;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_b_q, last_b_d;
`endif

  // Next-state logic: pending capture, grant selection and the access FSM.
  always_comb begin
    state_d    = state_q;
    a_pend_d   = a_pend_q;
    b_pend_d   = b_pend_q;
    a_we_d     = a_we_q;
    a_addr_d   = a_addr_q;
    a_din_d    = a_din_q;
    a_wtbt_d   = a_wtbt_q;
    b_we_d     = b_we_q;
    b_addr_d   = b_addr_q;
    b_din_d    = b_din_q;
    b_wtbt_d   = b_wtbt_q;
    gnt_b_d    = gnt_b_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wtbt_d = mem_wtbt_q;
    mem_we_d   = mem_we_q;
    mem_rd_d   = mem_rd_q;
    a_dout_d   = a_dout_q;
    b_dout_d   = b_dout_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_b_d   = last_b_q;
    pick_b_s   = b_pend_q && (!a_pend_q || !last_b_q);
`else
    pick_b_s   = b_pend_q && !a_pend_q;
`endif

    // A request while the port's entry is still pending is dropped on purpose.
    if (bus.a_req && !a_pend_q) begin
      a_pend_d = 1'b1;
      a_we_d   = bus.a_we;
      a_addr_d = bus.a_addr;
      a_din_d  = bus.a_din;
      a_wtbt_d = bus.a_wtbt;
    end else begin
      a_pend_d = a_pend_q;
    end
    if (bus.b_req && !b_pend_q) begin
      b_pend_d = 1'b1;
      b_we_d   = bus.b_we;
      b_addr_d = bus.b_addr;
      b_din_d  = bus.b_din;
      b_wtbt_d = bus.b_wtbt;
    end else begin
      b_pend_d = b_pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Only grant once the controller reports ready, so a fresh access never overlaps.
        if ((a_pend_q || b_pend_q) && bus.mem_ready) begin
          gnt_b_d    = pick_b_s;
          mem_addr_d = pick_b_s ? b_addr_q : a_addr_q;
          mem_din_d  = pick_b_s ? b_din_q  : a_din_q;
          mem_wtbt_d = pick_b_s ? b_wtbt_q : a_wtbt_q;
          mem_we_d   = pick_b_s ? b_we_q   : a_we_q;
          mem_rd_d   = pick_b_s ? !b_we_q  : !a_we_q;
          state_d    = ST_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          if (a_pend_q && b_pend_q) begin
            last_b_d = pick_b_s;
          end else begin
            last_b_d = last_b_q;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          if (gnt_b_q) begin
            b_ack_d  = 1'b1;
            b_pend_d = 1'b0;
            b_dout_d = mem_we_q ? b_dout_q : bus.mem_dout;
          end else begin
            a_ack_d  = 1'b1;
            a_pend_d = 1'b0;
            a_dout_d = mem_we_q ? a_dout_q : bus.mem_dout;
          end
          mem_we_d = 1'b0;
          mem_rd_d = 1'b0;
          state_d  = ST_GAP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_we_d = 1'b0;
        mem_rd_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      a_we_q     <= 1'b0;
      a_addr_q   <= 25'd0;
      a_din_q    <= 16'd0;
      a_wtbt_q   <= 2'd0;
      b_we_q     <= 1'b0;
      b_addr_q   <= 25'd0;
      b_din_q    <= 16'd0;
      b_wtbt_q   <= 2'd0;
      gnt_b_q    <= 1'b0;
      mem_addr_q <= 25'd0;
      mem_din_q  <= 16'd0;
      mem_wtbt_q <= 2'd0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      a_dout_q   <= 16'd0;
      b_dout_q   <= 16'd0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_pend_q   <= a_pend_d;
      b_pend_q   <= b_pend_d;
      a_we_q     <= a_we_d;
      a_addr_q   <= a_addr_d;
      a_din_q    <= a_din_d;
      a_wtbt_q   <= a_wtbt_d;
      b_we_q     <= b_we_d;
      b_addr_q   <= b_addr_d;
      b_din_q    <= b_din_d;
      b_wtbt_q   <= b_wtbt_d;
      gnt_b_q    <= gnt_b_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wtbt_q <= mem_wtbt_d;
      mem_we_q   <= mem_we_d;
      mem_rd_q   <= mem_rd_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last contested winner; resets to B so A wins the first contest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  assign bus.a_busy   = a_pend_q;
  assign bus.b_busy   = b_pend_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_dout   = a_dout_q;
  assign bus.b_dout   = b_dout_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_wtbt = mem_wtbt_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: a cycle table for a read and a
// contested write pair, plus hand sequences for arbitration order, back-to-back reads and reset.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  sdram_arbiter_if bus();
  sdram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic EXP_PAIR2_FIRST_B = 1'b1;
`else
  localparam logic EXP_PAIR2_FIRST_B = 1'b0;
`endif

  typedef struct {
    logic        ar, br, awe, bwe, rdy;
    logic [15:0] mdo;
    logic        rd, we, aack, abusy, back, bbusy;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests, clock it, sample #1 after the edge.
  task automatic cyc(input logic ar, input logic br, input logic rdy);
    bus.a_req     = ar;
    bus.b_req     = br;
    bus.mem_ready = rdy;
    @(posedge clk);
    #1;
    chk("strobe_excl", {31'd0, bus.mem_we & bus.mem_rd}, 32'd0);
  endtask

  // Bounded wait for a port's ack with mem_ready held high; lat counts from the req cycle.
  task automatic wait_ack(input logic port_b, output int lat);
    lat = 0;
    for (int i = 2; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if ((port_b ? bus.b_ack : bus.a_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int nack;
    int first_b;
    logic [24:0] seen_addr;

    reset = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 25'h0000100;
    bus.a_din = 16'hABCD; bus.a_wtbt = 2'b10;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 25'h1ABCDEF;
    bus.b_din = 16'h5555; bus.b_wtbt = 2'b01;
    bus.mem_dout = 16'h0000; bus.mem_ready = 1'b0;

    //      ar    br    awe   bwe   rdy   mdo       rd    we    aack  abusy back  bbusy addr          din       wtbt
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 25'h0000000, 16'h0000, 2'b00};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 25'h0000100, 16'hABCD, 2'b10};
    vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 25'h0000100, 16'hABCD, 2'b10};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 25'h0000100, 16'hABCD, 2'b10};
    vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,16'h1234, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 25'h0000100, 16'hABCD, 2'b10};
    vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,16'h1234, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 25'h0000100, 16'hABCD, 2'b10};
    vt[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 25'h0000100, 16'hABCD, 2'b10};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 25'h0000100, 16'hABCD, 2'b10};
    vt[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 25'h0000100, 16'hABCD, 2'b10};
    vt[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 25'h0000100, 16'hABCD, 2'b10};
    vt[10] = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 25'h0000100, 16'hABCD, 2'b10};
    vt[11] = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 25'h0000100, 16'hABCD, 2'b10};
    vt[12] = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 25'h1ABCDEF, 16'h5555, 2'b01};
    vt[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 25'h1ABCDEF, 16'h5555, 2'b01};
    vt[14] = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 25'h1ABCDEF, 16'h5555, 2'b01};
    vt[15] = '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 25'h1ABCDEF, 16'h5555, 2'b01};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_busy", {30'd0, bus.a_busy, bus.b_busy}, 32'd0);
    chk("rst_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("rst_mem_addr", {7'd0, bus.mem_addr}, 32'd0);
    chk("rst_dout", {bus.a_dout, bus.b_dout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single A read, then a contested write pair (A first in both builds)
    for (int i = 0; i < 16; i++) begin
      bus.a_we = vt[i].awe;
      bus.b_we = vt[i].bwe;
      bus.mem_dout = vt[i].mdo;
      cyc(vt[i].ar, vt[i].br, vt[i].rdy);
      chk($sformatf("v%0d_rd", i), {31'd0, bus.mem_rd}, {31'd0, vt[i].rd});
      chk($sformatf("v%0d_we", i), {31'd0, bus.mem_we}, {31'd0, vt[i].we});
      chk($sformatf("v%0d_ack", i), {30'd0, bus.a_ack, bus.b_ack}, {30'd0, vt[i].aack, vt[i].back});
      chk($sformatf("v%0d_busy", i), {30'd0, bus.a_busy, bus.b_busy}, {30'd0, vt[i].abusy, vt[i].bbusy});
      chk($sformatf("v%0d_addr", i), {7'd0, bus.mem_addr}, {7'd0, vt[i].addr});
      chk($sformatf("v%0d_din", i), {16'd0, bus.mem_din}, {16'd0, vt[i].din});
      chk($sformatf("v%0d_wtbt", i), {30'd0, bus.mem_wtbt}, {30'd0, vt[i].wtbt});
    end
    chk("a_dout_read", {16'd0, bus.a_dout}, 32'h0000_1234);
    chk("b_dout_untouched", {16'd0, bus.b_dout}, 32'd0);

    // Second contested pair: order depends on the arbitration build
    bus.a_we = 1'b1; bus.b_we = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    nack = 0;
    first_b = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (bus.a_ack === 1'b1 && bus.b_ack === 1'b1) begin
        chk("pair2_dual_ack", 32'd1, 32'd0);
      end else begin
        if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
          if (nack == 0) first_b = (bus.b_ack === 1'b1) ? 1 : 0;
          nack++;
        end
      end
    end
    chk("pair2_acks", nack, 32'd2);
    chk("pair2_first_b", first_b, {31'd0, EXP_PAIR2_FIRST_B});

    // Back-to-back B reads with mem_ready held high; second req on the ack cycle
    bus.b_we = 1'b0; bus.b_addr = 25'h1ABCDEF; bus.mem_dout = 16'h00C3;
    cyc(1'b0, 1'b1, 1'b1);
    wait_ack(1'b1, lat);
    chk("b2b_lat1", lat, 32'd4);
    chk("b2b_gap_rd_low", {31'd0, bus.mem_rd}, 32'd0);
    chk("b2b_busy_on_ack", {31'd0, bus.b_busy}, 32'd0);
    chk("b2b_dout1", {16'd0, bus.b_dout}, 32'h0000_00C3);
    bus.mem_dout = 16'h003C;
    cyc(1'b0, 1'b1, 1'b1);
    chk("b2b_req2_taken", {31'd0, bus.b_busy}, 32'd1);
    wait_ack(1'b1, lat);
    chk("b2b_lat2", lat, 32'd4);
    chk("b2b_dout2", {16'd0, bus.b_dout}, 32'h0000_003C);

    // b_req while busy is ignored: one ack, original address kept
    cyc(1'b0, 1'b1, 1'b1);
    bus.b_addr = 25'h0000222;
    cyc(1'b0, 1'b1, 1'b1);
    chk("ign_busy", {31'd0, bus.b_busy}, 32'd1);
    nack = 0;
    seen_addr = 25'd0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (bus.mem_rd === 1'b1) seen_addr = bus.mem_addr;
      if (bus.b_ack === 1'b1) nack++;
    end
    chk("ign_acks", nack, 32'd1);
    chk("ign_addr", {7'd0, seen_addr}, {7'd0, 25'h1ABCDEF});

    // Reset during WAIT abandons the access
    bus.a_we = 1'b0; bus.mem_dout = 16'hDEAD;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_wait_rd_before", {31'd0, bus.mem_rd}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_async_busy", {31'd0, bus.a_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (bus.a_ack === 1'b1) nack++;
    end
    chk("rst_no_ack", nack, 32'd0);
    chk("rst_a_dout", {16'd0, bus.a_dout}, 32'd0);

    // New request waits for mem_ready in IDLE, then completes normally
    bus.mem_dout = 16'h5A5A;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("hold_until_ready", {31'd0, bus.mem_rd}, 32'd0);
    chk("hold_busy", {31'd0, bus.a_busy}, 32'd1);
    wait_ack(1'b0, lat);
    chk("post_rst_ack_seen", {31'd0, lat != 0}, 32'd1);
    chk("post_rst_dout", {16'd0, bus.a_dout}, 32'h0000_5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
